// File: rtl/bit_reverse_stream.sv
// bit_reverse_stream
// Reorders DEPTH-sample frames from natural index order into bit-reversed
// index order ahead of the FFT core, with valid/ready flow control on both
// sides. Two ping-pong RAM banks hold frames; a 2-entry output skid absorbs
// the synchronous RAM read latency so backpressure never loses a sample.
//
// Ports:
//   mclk       rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_vld      input sample valid
//   i_new_fft  input sample is natural index 0 of a frame (qualified by i_vld)
//   i_data     input sample payload
//   o_rdy      block can accept an input sample this cycle
//   i_rdy      downstream can accept an output sample this cycle
//   o_vld      output sample valid
//   o_new_fft  output sample is the first of a frame (bit-reversed index 0)
//   o_data     output sample payload
module bit_reverse_stream #(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 128
) (
   input  logic              mclk,
   input  logic              i_rst_n,
   input  logic              i_vld,
   input  logic              i_new_fft,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_rdy,
   input  logic              i_rdy,
   output logic              o_vld,
   output logic              o_new_fft,
   output logic [DATA_W-1:0] o_data
);

   localparam int C_W = $clog2(DEPTH);
   localparam logic [C_W-1:0] LAST = C_W'(DEPTH - 1);

   function automatic logic [C_W-1:0] bitrev(input logic [C_W-1:0] v);
      logic [C_W-1:0] r;
      for (int i = 0; i < C_W; i++) begin
         r[i] = v[C_W-1-i];
      end
      return r;
   endfunction

   logic [DATA_W-1:0] mem_a [DEPTH];
   logic [DATA_W-1:0] mem_b [DEPTH];
   logic [DATA_W-1:0] ram_dout;

   logic              sync_q, sync_d;
   logic              wr_bank_q, wr_bank_d;
   logic [C_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic [1:0]        full_q, full_d;
   logic              rd_bank_q, rd_bank_d;
   logic [C_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic              inflight_q, inflight_d;
   logic              inflight_sof_q, inflight_sof_d;
   logic [DATA_W-1:0] skid0_q, skid0_d;
   logic [DATA_W-1:0] skid1_q, skid1_d;
   logic [1:0]        skid_sof_q, skid_sof_d;
   logic              skid_head_q, skid_head_d;
   logic [1:0]        skid_cnt_q, skid_cnt_d;

   logic              accept;
   logic              wr_en;
   logic [C_W-1:0]    wr_addr;
   logic              set_full;
   logic              pop;
   logic [2:0]        occ;
   logic              rd_issue;
   logic [C_W-1:0]    rd_addr;
   logic              skid_widx;

   assign o_rdy  = ~full_q[wr_bank_q];
   assign accept = i_vld & o_rdy;

   // Write side: frame alignment and natural-order fill. A start-of-frame
   // sample always restarts the current bank at address 0, abandoning any
   // partial frame. A synced sample arriving at count 0 means the previous
   // frame completed and the start flag is missing, so sync is lost.
   always_comb begin
      sync_d    = sync_q;
      wr_bank_d = wr_bank_q;
      wr_cnt_d  = wr_cnt_q;
      wr_en     = 1'b0;
      wr_addr   = wr_cnt_q;
      set_full  = 1'b0;
      if (accept) begin
         if (i_new_fft) begin
            wr_en    = 1'b1;
            wr_addr  = '0;
            wr_cnt_d = C_W'(1);
            sync_d   = 1'b1;
         end else if (sync_q) begin
            if (wr_cnt_q == '0) begin
               sync_d = 1'b0;
            end else begin
               wr_en = 1'b1;
               if (wr_cnt_q == LAST) begin
                  set_full  = 1'b1;
                  wr_bank_d = ~wr_bank_q;
                  wr_cnt_d  = '0;
               end else begin
                  wr_cnt_d = wr_cnt_q + C_W'(1);
               end
            end
         end
      end
   end

   // Read side: issue a bit-reversed read whenever the read bank is full and
   // the skid plus the in-flight RAM read still has room after this cycle's
   // pop. Counting the pop keeps the output gapless at one sample per cycle.
   always_comb begin
      pop       = o_vld & i_rdy;
      occ       = 3'(inflight_q) + 3'(skid_cnt_q) - 3'(pop);
      rd_issue  = full_q[rd_bank_q] & (occ < 3'd2);
      rd_addr   = bitrev(rd_cnt_q);
      rd_bank_d = rd_bank_q;
      rd_cnt_d  = rd_cnt_q;
      full_d    = full_q;
      if (set_full) begin
         full_d[wr_bank_q] = 1'b1;
      end
      if (rd_issue) begin
         if (rd_cnt_q == LAST) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + C_W'(1);
         end
      end
      inflight_d     = rd_issue;
      inflight_sof_d = rd_issue & (rd_cnt_q == '0);
   end

   // Output skid: the RAM word read last cycle lands in the slot after the
   // current head; a consumed sample advances the head.
   always_comb begin
      skid0_d     = skid0_q;
      skid1_d     = skid1_q;
      skid_sof_d  = skid_sof_q;
      skid_head_d = skid_head_q;
      skid_widx   = skid_head_q ^ skid_cnt_q[0];
      if (inflight_q) begin
         if (skid_widx) begin
            skid1_d       = ram_dout;
            skid_sof_d[1] = inflight_sof_q;
         end else begin
            skid0_d       = ram_dout;
            skid_sof_d[0] = inflight_sof_q;
         end
      end
      if (pop) begin
         skid_head_d = ~skid_head_q;
      end
      skid_cnt_d = skid_cnt_q + 2'(inflight_q) - 2'(pop);
   end

   assign o_vld     = (skid_cnt_q != 2'd0);
   assign o_data    = skid_head_q ? skid1_q : skid0_q;
   assign o_new_fft = o_vld & skid_sof_q[skid_head_q];

   // Bank storage and synchronous read port; contents need no reset because
   // the full flags and in-flight tag decide what is ever presented.
   always_ff @(posedge mclk) begin
      if (wr_en & ~wr_bank_q) mem_a[wr_addr] <= i_data;
      if (wr_en & wr_bank_q)  mem_b[wr_addr] <= i_data;
      if (rd_issue) ram_dout <= rd_bank_q ? mem_b[rd_addr] : mem_a[rd_addr];
   end

   // Control state register.
   always_ff @(posedge mclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q         <= 1'b0;
         wr_bank_q      <= 1'b0;
         wr_cnt_q       <= '0;
         full_q         <= '0;
         rd_bank_q      <= 1'b0;
         rd_cnt_q       <= '0;
         inflight_q     <= 1'b0;
         inflight_sof_q <= 1'b0;
         skid0_q        <= '0;
         skid1_q        <= '0;
         skid_sof_q     <= '0;
         skid_head_q    <= 1'b0;
         skid_cnt_q     <= '0;
      end else begin
         sync_q         <= sync_d;
         wr_bank_q      <= wr_bank_d;
         wr_cnt_q       <= wr_cnt_d;
         full_q         <= full_d;
         rd_bank_q      <= rd_bank_d;
         rd_cnt_q       <= rd_cnt_d;
         inflight_q     <= inflight_d;
         inflight_sof_q <= inflight_sof_d;
         skid0_q        <= skid0_d;
         skid1_q        <= skid1_d;
         skid_sof_q     <= skid_sof_d;
         skid_head_q    <= skid_head_d;
         skid_cnt_q     <= skid_cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_reverse_stream.sv
// Testbench for bit_reverse_stream with DEPTH=8. A frame-level reference
// model turns accepted input samples into expected output samples; a
// monitor pops and compares whenever the block hands over a sample.
module tb_bit_reverse_stream;

   localparam int DATA_W = 20;
   localparam int DEPTH  = 8;
   localparam int LOG2D  = 3;

   logic              mclk;
   logic              i_rst_n;
   logic              i_vld;
   logic              i_new_fft;
   logic [DATA_W-1:0] i_data;
   logic              o_rdy;
   logic              i_rdy;
   logic              o_vld;
   logic              o_new_fft;
   logic [DATA_W-1:0] o_data;

   bit_reverse_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .mclk      (mclk),
      .i_rst_n   (i_rst_n),
      .i_vld     (i_vld),
      .i_new_fft (i_new_fft),
      .i_data    (i_data),
      .o_rdy     (o_rdy),
      .i_rdy     (i_rdy),
      .o_vld     (o_vld),
      .o_new_fft (o_new_fft),
      .o_data    (o_data)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sof;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] cur_frame[$];
   bit                synced;

   int checks_total  = 0;
   int checks_passed = 0;
   int cyc           = 0;
   int pops          = 0;
   int gaps          = 0;
   int last_pop_cyc  = 0;
   bit first_pop     = 1'b1;
   int acc_count     = 0;
   int in_stalls     = 0;
   bit prev_stall    = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic              prev_sof;
   bit rnd_on        = 1'b0;

   // Every comparison goes through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks_total++;
      if (act === req) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int revIndex(input int k);
      int r = 0;
      for (int b = 0; b < LOG2D; b++) begin
         r = r * 2 + ((k >> b) & 1);
      end
      return r;
   endfunction

   // Reference model: collect a frame in natural order; once it holds DEPTH
   // samples, emit it in bit-reversed order with the start flag on the first.
   function automatic void modelAccept(input logic sof, input logic [DATA_W-1:0] d);
      exp_t e;
      if (sof) begin
         cur_frame.delete();
         cur_frame.push_back(d);
         synced = 1'b1;
      end else if (synced) begin
         if (cur_frame.size() == 0) begin
            synced = 1'b0;
         end else begin
            cur_frame.push_back(d);
         end
      end
      if (cur_frame.size() == DEPTH) begin
         for (int k = 0; k < DEPTH; k++) begin
            e.data = cur_frame[revIndex(k)];
            e.sof  = (k == 0);
            exp_q.push_back(e);
         end
         cur_frame.delete();
      end
   endfunction

   // Monitor on the falling edge: handshakes seen here complete on the next
   // rising edge, since inputs only change just after rising edges.
   always @(negedge mclk) begin
      exp_t e;
      cyc++;
      if (!i_rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (i_vld && o_rdy) begin
            acc_count++;
            modelAccept(i_new_fft, i_data);
         end else if (i_vld) begin
            in_stalls++;
         end
         if (prev_stall) begin
            checkOutput("stall_hold_vld", 32'(o_vld), 32'd1);
            checkOutput("stall_hold_data", 32'(o_data), 32'(prev_data));
            checkOutput("stall_hold_sof", 32'(o_new_fft), 32'(prev_sof));
         end
         if (o_vld && i_rdy) begin
            if (exp_q.size() == 0) begin
               checkOutput("spurious_output", 32'(o_vld), 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("out_data", 32'(o_data), 32'(e.data));
               checkOutput("out_sof", 32'(o_new_fft), 32'(e.sof));
            end
            if (!first_pop && (cyc - last_pop_cyc) > 1) gaps++;
            first_pop    = 1'b0;
            last_pop_cyc = cyc;
            pops++;
         end
         prev_stall = o_vld && !i_rdy;
         prev_data  = o_data;
         prev_sof   = o_new_fft;
      end
   end

   // Offer one sample and hold it until accepted (bounded).
   task automatic applyStimulus(input logic sof, input logic [DATA_W-1:0] d);
      bit ok = 1'b0;
      int n  = 0;
      i_vld     = 1'b1;
      i_new_fft = sof;
      i_data    = d;
      while (!ok && n < 300) begin
         @(negedge mclk);
         ok = o_rdy;
         @(posedge mclk);
         #1;
         n++;
      end
      if (!ok) checkOutput("accept_timeout", 32'(o_rdy), 32'd1);
      i_vld     = 1'b0;
      i_new_fft = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge mclk);
         #1;
      end
   endtask

   task automatic doReset();
      i_rst_n = 1'b0;
      #1;
      checkOutput("reset_o_vld", 32'(o_vld), 32'd0);
      checkOutput("reset_o_new_fft", 32'(o_new_fft), 32'd0);
      checkOutput("reset_o_data", 32'(o_data), 32'd0);
      checkOutput("reset_o_rdy", 32'(o_rdy), 32'd1);
      exp_q.delete();
      cur_frame.delete();
      synced = 1'b0;
      idle(2);
      i_rst_n = 1'b1;
      idle(1);
   endtask

   task automatic waitDrain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         @(posedge mclk);
         #1;
         n++;
      end
      checkOutput("drain_remaining", 32'(exp_q.size()), 32'd0);
      idle(10);
   endtask

   initial begin
      int n;
      int pops_before;
      bit miss;
      int len;
      i_rst_n   = 1'b0;
      i_vld     = 1'b0;
      i_new_fft = 1'b0;
      i_data    = '0;
      i_rdy     = 1'b1;
      synced    = 1'b0;

      // Single frame, latency from last accept to first valid output.
      doReset();
      for (int k = 0; k < DEPTH; k++) applyStimulus(k == 0, DATA_W'(k));
      n = 0;
      while (!o_vld && n < 20) begin
         @(posedge mclk);
         #1;
         n++;
      end
      checkOutput("fill_latency_edges", 32'(n), 32'd2);
      waitDrain(100);

      // Four back-to-back frames: no input stall, gapless output.
      doReset();
      first_pop = 1'b1;
      gaps      = 0;
      pops      = 0;
      in_stalls = 0;
      for (int k = 0; k < 4 * DEPTH; k++) applyStimulus((k % DEPTH) == 0, DATA_W'(100 + k));
      waitDrain(100);
      checkOutput("stream_pops", 32'(pops), 32'd32);
      checkOutput("stream_gaps", 32'(gaps), 32'd0);
      checkOutput("stream_in_stalls", 32'(in_stalls), 32'd0);

      // Downstream stalled: both banks fill, then everything drains.
      doReset();
      i_rdy     = 1'b0;
      acc_count = 0;
      pops      = 0;
      fork
         begin
            for (int k = 0; k < 3 * DEPTH; k++) applyStimulus((k % DEPTH) == 0, DATA_W'(200 + k));
         end
         begin
            n = 0;
            do begin
               @(negedge mclk);
               n++;
            end while (o_rdy && n < 100);
            checkOutput("accepts_before_full", 32'(acc_count), 32'd16);
            idle(5);
            i_rdy = 1'b1;
         end
      join
      waitDrain(200);
      checkOutput("stall_pops", 32'(pops), 32'd24);

      // Unsynced samples are dropped until a start flag arrives.
      doReset();
      for (int k = 1; k <= 5; k++) applyStimulus(1'b0, DATA_W'(k));
      for (int k = 0; k < DEPTH; k++) applyStimulus(k == 0, DATA_W'(10 + k));
      waitDrain(100);

      // Partial frame abandoned by a new start flag.
      doReset();
      for (int k = 0; k < 3; k++) applyStimulus(k == 0, DATA_W'(k));
      for (int k = 0; k < DEPTH; k++) applyStimulus(k == 0, DATA_W'(20 + k));
      waitDrain(100);

      // Reset mid-drain, then nothing until a fresh complete frame.
      doReset();
      for (int k = 0; k < DEPTH; k++) applyStimulus(k == 0, DATA_W'(30 + k));
      n = 0;
      while (!o_vld && n < 20) begin
         @(posedge mclk);
         #1;
         n++;
      end
      idle(2);
      doReset();
      pops_before = pops;
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, DATA_W'(50 + k));
      idle(20);
      checkOutput("post_reset_pops", 32'(pops - pops_before), 32'd0);
      for (int k = 0; k < DEPTH; k++) applyStimulus(k == 0, DATA_W'(40 + k));
      waitDrain(100);

      // Randomized traffic: random data, gaps, backpressure, aborts and
      // missing start flags.
      doReset();
      rnd_on = 1'b1;
      fork
         begin
            for (int f = 0; f < 40; f++) begin
               miss = ($urandom_range(0, 7) == 0);
               len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, DEPTH - 1)) : DEPTH;
               for (int k = 0; k < len; k++) begin
                  applyStimulus((k == 0) && !miss, DATA_W'($urandom));
                  if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
               end
            end
            rnd_on = 1'b0;
         end
         begin
            while (rnd_on) begin
               @(posedge mclk);
               #1;
               i_rdy = ($urandom_range(0, 3) != 0);
            end
            i_rdy = 1'b1;
         end
      join
      i_rdy = 1'b1;
      waitDrain(500);

      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/bit_reverse_stream.md
# bit_reverse_stream

Natural-to-bit-reversed reorder buffer with valid/ready flow control on both sides. It sits ahead of the FFT core. It accepts DEPTH-sample frames in natural order and emits each frame in bit-reversed index order, using two ping-pong RAM banks. Frame alignment comes from an input start-of-frame flag. Downstream backpressure is absorbed by the banks and propagated upstream.

## Interface
Parameters:
- DATA_W, 20, sample width in bits (opaque payload).
- DEPTH, 128, frame length; power of 2, at least 4.
- C_W, $clog2(DEPTH), localparam, address and counter width.

Ports:
- mclk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_vld  in  1  input sample valid.
- i_new_fft  in  1  input sample is natural index 0 of a frame; qualified by i_vld.
- i_data  in  DATA_W  input sample.
- o_rdy  out  1  block can accept an input sample this cycle.
- i_rdy  in  1  downstream can accept an output sample this cycle.
- o_vld  out  1  output sample valid.
- o_new_fft  out  1  output sample is the first of a frame (bit-reversed index 0).
- o_data  out  DATA_W  output sample.

## Operation
- Input handshake: a sample is accepted when i_vld & o_rdy. Output handshake: a sample is consumed when o_vld & i_rdy.
- The block has two banks, A and B, each DEPTH x DATA_W with one synchronous read port. Each bank has a full flag.
- Write pointer state: wr_bank and wr_cnt[C_W-1:0].
- Read pointer state: rd_bank and rd_cnt[C_W-1:0].
- Sync flag:
  - Cleared by reset.
  - Set on an accepted sample with i_new_fft=1.
  - While clear, accepted samples are dropped and o_rdy=1.
- Write path:
  - An accepted synced sample is written to bank wr_bank at address wr_cnt (natural order); wr_cnt then increments.
  - An accepted sample with i_new_fft=1 always writes address 0 and sets wr_cnt=1. Any partial frame already in wr_bank is abandoned.
  - When the sample at address DEPTH-1 is written: set full[wr_bank], toggle wr_bank, set wr_cnt=0.
  - A frame completed with wr_cnt=0 expects i_new_fft on the next sample. If that sample has i_new_fft=0, clear sync and drop the sample.
- o_rdy = ~full[wr_bank] (combinational from registered state).
- Read path:
  - A read is issued while full[rd_bank] and output skid capacity is available. The read address is bitrev(rd_cnt), i.e. addr[i] = rd_cnt[C_W-1-i].
  - rd_cnt increments on each issue.
  - On issuing rd_cnt=DEPTH-1: clear full[rd_bank], toggle rd_bank, set rd_cnt=0.
  - Read data goes into a 2-entry output skid. At most 2 entries may be occupied or in flight at any time.
- o_new_fft is tagged on the sample read with rd_cnt=0.
- Output ordering example, DEPTH=8: natural indices 0,4,2,6,1,5,3,7.

## Timing
- Reset values: o_vld=0, o_new_fft=0, o_data=0, o_rdy=1. Also: full flags 0, counters 0, banks A for both write and read, sync 0.
- Reset is asynchronous. Asserting i_rst_n mid-frame or mid-drain drops all buffered data, and no stale sample appears after release.
- Fill latency:
  - The last sample of a frame is accepted at edge T; full is set after edge T.
  - The first read is issued at edge T+1.
  - o_vld=1 after edge T+2, provided i_rdy was high.
- Throughput:
  - 1 sample/cycle in and out.
  - Output is gapless across frame boundaries when input is continuous and i_rdy=1.
  - o_rdy never deasserts in this steady state, because the reader frees a bank before the writer needs it.
- Stalls: while o_vld & ~i_rdy, o_data and o_new_fft hold stable and no sample is lost.
- Both banks full: o_rdy=0. o_rdy returns to 1 the cycle after the last read of the draining bank is issued.
- Simultaneous events:
  - A write to bank X and the final read issue from bank Y≠X in the same cycle are legal.
  - Writer and reader never target the same bank while it is full.
- i_new_fft at wr_cnt=0 is a normal frame start; it is not treated as an abort.

## Test plan
- DEPTH=8, i_rdy=1, feed 0..7 with i_new_fft on 0: output 0,4,2,6,1,5,3,7; o_new_fft with the 0; first o_vld 2 edges after full is set.
- Feed 4 back-to-back frames, i_rdy=1: o_rdy stays 1 throughout; 32 outputs gapless; each frame bit-reversed.
- i_rdy=0, feed 3 frames continuously: o_rdy drops after 16 accepts. Then release i_rdy: all 24 samples emerge in order, o_data stable during the stall.
- After reset, feed 5 samples with no i_new_fft, then a proper frame 10..17: only 10,14,12,16,11,15,13,17 appear.
- Frame 0..2 then i_new_fft with 20..27: the partial frame is discarded; output is 20,24,22,26,21,25,23,27.
- Pulse i_rst_n low mid-drain: o_vld=0 immediately. After release o_rdy=1, nothing is output until a new complete frame arrives.
